dpram_sync_rw: RTL and testbench

Generic two-port synchronous RAM: one dedicated write port and one dedicated read port, both clocked by a single clock. It is the internal data RAM of the 8051 core, 256 x 8 by default, with registered read data. It replaces the vendor and behavioural RAM variants with one technology-neutral block. The read port supports same-cycle write-to-read forwarding when the optional feature is enabled.

---
 rtl/dpram_pkg.sv | 17 +
 rtl/dpram_sync_rw_if.sv | 41 ++++
 rtl/dpram_mem_array.sv | 29 ++
 rtl/dpram_sync_rw.sv | 62 ++++++
 tb/tb_dpram_sync_rw.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/dpram_pkg.sv
// Shared constants for the generic two-port synchronous RAM.
// Imported by the interface, the storage array and the top level.
package dpram_pkg;

  localparam int DPRAM_DEF_AW = 8;
  localparam int DPRAM_DEF_DW = 8;

  localparam int unsigned DPRAM_RD_RST = '0;

  function automatic logic addr_hit(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return a == b;
  endfunction

endpackage

// File: rtl/dpram_sync_rw_if.sv
// Port bundle of the two-port RAM: one write port, one read port.
// The master drives addresses and data, the slave returns rd_data.
interface dpram_sync_rw_if
  import dpram_pkg::*;
#(
  parameter int AW = DPRAM_DEF_AW,
  parameter int DW = DPRAM_DEF_DW
);

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          oe;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output rd_en,
    output rd_addr,
    output oe,
    input  rd_data,
    output wr_en,
    output wr,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    input  oe,
    output rd_data,
    input  wr_en,
    input  wr,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/dpram_mem_array.sv
// Bare 2**AW x DW storage: clocked write port, asynchronous read tap.
// Kept separate so a vendor macro can replace it.
module dpram_mem_array
  import dpram_pkg::*;
#(
  parameter int AW = DPRAM_DEF_AW,
  parameter int DW = DPRAM_DEF_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dpram_sync_rw.sv
// Two-port synchronous RAM with registered read data and oe gating.
// DPRAM_WR_BYPASS_EN: same-cycle same-address write-to-read forwarding.
module dpram_sync_rw
  import dpram_pkg::*;
#(
  parameter int AW = DPRAM_DEF_AW,
  parameter int DW = DPRAM_DEF_DW
) (
  input logic            clk,
  input logic            rst,
  dpram_sync_rw_if.slave bus
);

  logic          we;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] rd_next;
  logic [DW-1:0] rd_q;

  assign we = bus.wr_en & bus.wr;

  dpram_mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (bus.rd_addr),
    .rdata (mem_q)
  );

`ifdef DPRAM_WR_BYPASS_EN
  logic hit;

  assign hit = we & addr_hit(32'(bus.rd_addr),
                             32'(bus.wr_addr));

  always_comb begin
    rd_next = mem_q;
    if (hit) begin
      rd_next = bus.wr_data;
    end
  end
`else
  // Read-first: the array tap still shows pre-write contents.
  always_comb begin
    rd_next = mem_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= DW'(DPRAM_RD_RST);
    end else if (bus.rd_en) begin
      rd_q <= rd_next;
    end
  end

  assign bus.rd_data = bus.oe ? rd_q : '0;

endmodule

// File: tb/tb_dpram_sync_rw.sv
// Directed bench for dpram_sync_rw (256 x 8, either bypass build).
// Expected values are hand-computed constants and addr ^ 8'hA5.
module tb_dpram_sync_rw;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  dpram_sync_rw_if #(.AW(8), .DW(8)) bus ();

  dpram_sync_rw #(
    .AW (8),
    .DW (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(
    input logic       en,
    input logic       st,
    input logic [7:0] a,
    input logic [7:0] d
  );
    bus.wr_en   = en;
    bus.wr      = st;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic set_rd(
    input logic       en,
    input logic [7:0] a
  );
    bus.rd_en   = en;
    bus.rd_addr = a;
  endtask

  logic [7:0] exp_col;

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.oe = 1'b1;
    set_rd(1'b1, 8'h00);
    set_wr(1'b0, 1'b0, 8'h00, 8'h00);

    tick();
    tick();
    chk("reset", bus.rd_data, 8'h00);

    rst = 1'b0;
    set_rd(1'b0, 8'h00);
    set_wr(1'b1, 1'b1, 8'h10, 8'h5A);
    tick();
    chk("rden0_hold_rst", bus.rd_data, 8'h00);
    set_wr(1'b0, 1'b0, 8'h00, 8'h00);
    set_rd(1'b1, 8'h10);
    tick();
    chk("first_read", bus.rd_data, 8'h5A);

    set_rd(1'b0, 8'h00);
    for (int a = 0; a < 256; a++) begin
      set_wr(1'b1, 1'b1, 8'(a), 8'(a) ^ 8'hA5);
      tick();
    end
    set_wr(1'b0, 1'b0, 8'h00, 8'h00);
    for (int a = 0; a < 256; a++) begin
      set_rd(1'b1, 8'(a));
      tick();
      chk($sformatf("sweep_%02h", a), bus.rd_data,
          8'(a) ^ 8'hA5);
    end

    set_wr(1'b1, 1'b1, 8'h20, 8'h11);
    tick();
    set_wr(1'b1, 1'b0, 8'h20, 8'h33);
    tick();
    set_wr(1'b0, 1'b1, 8'h20, 8'h44);
    tick();
    set_wr(1'b0, 1'b0, 8'h00, 8'h00);
    set_rd(1'b1, 8'h20);
    tick();
    chk("wr_gating", bus.rd_data, 8'h11);

    set_wr(1'b1, 1'b1, 8'h60, 8'h99);
    set_rd(1'b1, 8'h20);
    tick();
    chk("indep_rd", bus.rd_data, 8'h11);
    set_wr(1'b0, 1'b0, 8'h00, 8'h00);
    set_rd(1'b1, 8'h60);
    tick();
    chk("indep_wr", bus.rd_data, 8'h99);

    set_wr(1'b1, 1'b1, 8'h40, 8'h11);
    set_rd(1'b0, 8'h00);
    tick();
    set_wr(1'b1, 1'b1, 8'h40, 8'h77);
    set_rd(1'b1, 8'h40);
    tick();
`ifdef DPRAM_WR_BYPASS_EN
    exp_col = 8'h77;
`else
    exp_col = 8'h11;
`endif
    chk("collision", bus.rd_data, exp_col);
    set_wr(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("after_collision", bus.rd_data, 8'h77);

    set_wr(1'b1, 1'b1, 8'h10, 8'h5A);
    set_rd(1'b0, 8'h00);
    tick();
    set_wr(1'b0, 1'b0, 8'h00, 8'h00);
    set_rd(1'b1, 8'h10);
    tick();
    chk("hold_base", bus.rd_data, 8'h5A);
    set_rd(1'b0, 8'h20);
    tick();
    chk("hold_1", bus.rd_data, 8'h5A);
    set_rd(1'b0, 8'h40);
    tick();
    chk("hold_2", bus.rd_data, 8'h5A);
    set_rd(1'b0, 8'hFF);
    tick();
    chk("hold_3", bus.rd_data, 8'h5A);

    bus.oe = 1'b0;
    #1;
    chk("oe_low", bus.rd_data, 8'h00);
    tick();
    chk("oe_low_clk", bus.rd_data, 8'h00);
    bus.oe = 1'b1;
    #1;
    chk("oe_back", bus.rd_data, 8'h5A);

    rst = 1'b1;
    set_rd(1'b1, 8'h10);
    set_wr(1'b1, 1'b1, 8'h50, 8'h66);
    tick();
    chk("mid_reset", bus.rd_data, 8'h00);
    rst = 1'b0;
    set_wr(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("mem_kept", bus.rd_data, 8'h5A);
    set_rd(1'b1, 8'h50);
    tick();
    chk("wr_during_rst", bus.rd_data, 8'h66);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
